// File: rtl/add32_seq.sv
// 32-bit sequential adder that time-shares one 16-bit Brent-Kung adder over two cycles.
// Optional subtract mode is enabled by defining ADD32_SUB_EN (adds the sub input).

module brent_kung16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        carry
);

   // Parallel-prefix carry tree: up-sweep builds power-of-two groups, down-sweep fills the gaps.
   always_comb begin : bk_tree
      logic [15:0] w_gg;
      logic [15:0] w_pp;
      logic [15:0] w_pb;
      w_pb = a ^ b;
      w_gg = a & b;
      w_pp = w_pb;
      // Carry-in folds into bit 0 so every group generate already includes it.
      w_gg[0] = w_gg[0] | (w_pb[0] & cin);
      for (int l = 0; l < 4; l++) begin
         for (int i = (2 << l) - 1; i < 16; i += (2 << l)) begin
            w_gg[i] = w_gg[i] | (w_pp[i] & w_gg[i - (1 << l)]);
            w_pp[i] = w_pp[i] & w_pp[i - (1 << l)];
         end
      end
      for (int l = 2; l >= 0; l--) begin
         for (int i = (3 << l) - 1; i < 16; i += (2 << l)) begin
            w_gg[i] = w_gg[i] | (w_pp[i] & w_gg[i - (1 << l)]);
            w_pp[i] = w_pp[i] & w_pp[i - (1 << l)];
         end
      end
      sum   = w_pb ^ {w_gg[14:0], cin};
      carry = w_gg[15];
   end

endmodule

module add32_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
`ifdef ADD32_SUB_EN
   input  logic        sub,
`endif
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] sum,
   output logic        cout,
   output logic        ovf
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic        r_cin;
   logic        r_c16;
   logic [31:0] r_sum;
   logic        r_cout;
   logic        r_ovf;
   logic [31:0] w_b_eff;
   logic        w_cin_eff;
   logic [15:0] w_add_a;
   logic [15:0] w_add_b;
   logic        w_add_cin;
   logic [15:0] w_add_sum;
   logic        w_add_carry;
   logic        w_accept;

`ifdef ADD32_SUB_EN
   logic        r_sub;

   // Subtraction is a + ~b + 1; cout then reads as "no borrow".
   always_comb begin
      if (r_sub) begin
         w_b_eff   = ~r_b;
         w_cin_eff = 1'b1;
      end else begin
         w_b_eff   = r_b;
         w_cin_eff = r_cin;
      end
   end
`else
   assign w_b_eff   = r_b;
   assign w_cin_eff = r_cin;
`endif

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;
   assign w_accept  = in_valid && (r_state == IDLE);

   // Select which half of the operands feeds the shared adder.
   always_comb begin
      if (r_state == LO) begin
         w_add_a   = r_a[15:0];
         w_add_b   = w_b_eff[15:0];
         w_add_cin = w_cin_eff;
      end else begin
         w_add_a   = r_a[31:16];
         w_add_b   = w_b_eff[31:16];
         w_add_cin = r_c16;
      end
   end

   brent_kung16bit u_bk (
      .a     (w_add_a),
      .b     (w_add_b),
      .cin   (w_add_cin),
      .sum   (w_add_sum),
      .carry (w_add_carry)
   );

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_state_nxt = LO;   else w_state_nxt = IDLE;
         LO:      w_state_nxt = HI;
         HI:      w_state_nxt = DONE;
         DONE:    if (out_ready) w_state_nxt = IDLE; else w_state_nxt = DONE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Operand capture and per-half result registers; results hold outside LO/HI.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a    <= 32'd0;
         r_b    <= 32'd0;
         r_cin  <= 1'b0;
`ifdef ADD32_SUB_EN
         r_sub  <= 1'b0;
`endif
         r_c16  <= 1'b0;
         r_sum  <= 32'd0;
         r_cout <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_a   <= a;
                  r_b   <= b;
                  r_cin <= cin;
`ifdef ADD32_SUB_EN
                  r_sub <= sub;
`endif
               end
            end
            LO: begin
               r_sum[15:0] <= w_add_sum;
               r_c16       <= w_add_carry;
            end
            HI: begin
               r_sum[31:16] <= w_add_sum;
               r_cout       <= w_add_carry;
               // Overflow: like-signed effective operands giving an opposite-signed result.
               r_ovf        <= (r_a[31] == w_b_eff[31]) && (w_add_sum[15] != r_a[31]);
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/add32_seq.md
ADD32_SEQ -- requirements
Module: add32_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: operand request valid.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept an operand request.
REQ-005 SHALL have port a, input, 32 bits: operand A.
REQ-006 SHALL have port b, input, 32 bits: operand B.
REQ-007 SHALL have port cin, input, 1 bit: carry-in.
REQ-008 SHALL have port out_valid, output, 1 bit: result valid.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 SHALL have port sum, output, 32 bits: registered result.
REQ-011 SHALL have port cout, output, 1 bit: unsigned carry-out of bit 31.
REQ-012 SHALL have port ovf, output, 1 bit: signed two's-complement overflow.
REQ-013 SHALL have port sub, input, 1 bit, present only when ADD32_SUB_EN is defined: subtract request.

Function
REQ-014 SHALL instantiate exactly one brent_kung16bit (a, b, cin, sum, carry) and time-share it across the two 16-bit halves.
REQ-015 SHALL implement the FSM states IDLE, LO, HI and DONE.
REQ-016 In IDLE, in_ready SHALL be 1; in every other state it SHALL be 0.
REQ-017 When in_valid and in_ready are both 1 at a rising edge, the block SHALL capture a, b and cin (and sub) into operand registers and move to LO.
REQ-018 In LO, the adder SHALL be driven with a[15:0], b[15:0] and the captured cin; the resulting sum SHALL be registered into sum[15:0] and the carry into an internal carry register c16; the FSM SHALL then move to HI.
REQ-019 In HI, the adder SHALL be driven with a[31:16], b[31:16] and c16; the result SHALL be registered into sum[31:16] and the carry into cout, ovf SHALL be registered, and the FSM SHALL then move to DONE.
REQ-020 ovf SHALL be 1 exactly when both effective operands have equal bit 31 and result bit 31 differs from it.
REQ-021 In DONE, out_valid SHALL be 1; sum, cout and ovf SHALL be held stable until the handshake completes.
REQ-022 When out_valid and out_ready are both 1, the FSM SHALL return to IDLE; in_ready SHALL rise on the following cycle, and no request SHALL be accepted in the same cycle as the output handshake.
REQ-023 Latency SHALL be 3 cycles from the accepting edge to out_valid=1 when out_ready is held high, giving one result per 4 cycles.
REQ-024 sum, cout and ovf SHALL retain their previous values outside DONE until they are overwritten in LO/HI; the value of sum outside DONE is not meaningful to the consumer.
REQ-025 Arithmetic SHALL be modulo 2^32; cout SHALL carry the 33rd bit.
REQ-026 While the block is not in IDLE, in_valid, a, b, cin and sub SHALL be ignored.

Reset
REQ-027 Asserting rst at any time, including in LO, HI or DONE, SHALL immediately force state=IDLE, out_valid=0, in_ready=1, sum=0, cout=0, ovf=0 and c16=0, and SHALL clear the operand registers.
REQ-028 An operation interrupted by reset SHALL be discarded, and no result SHALL be issued for it.
REQ-029 The first request SHALL be accepted at the first rising edge after rst deasserts.

Configuration
REQ-030 With ADD32_SUB_EN defined, when the captured sub is 1 the block SHALL use ~b as the effective B and force the effective cin to 1, producing a-b; cout SHALL then mean "no borrow", and ovf SHALL use the effective B.
REQ-031 With ADD32_SUB_EN undefined, the sub port and its logic SHALL be absent and the block SHALL only add.

Verification
REQ-032 a=0x0000FFFF, b=0x00000001, cin=0 -> sum=0x00010000, cout=0, ovf=0, out_valid 3 cycles after accept.
REQ-033 a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1, ovf=0.
REQ-034 a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, ovf=1, cout=0.
REQ-035 out_ready held 0 for 5 cycles in DONE -> out_valid stays 1, sum stable, in_ready=0 and a new in_valid is ignored; after out_ready=1, in_ready rises 1 cycle later.
REQ-036 rst asserted during HI -> out_valid=0, sum=0 asynchronously, no result emitted; next request 0x1+0x2 -> sum=0x3.
REQ-037 With ADD32_SUB_EN defined, sub=1, a=5, b=7 -> sum=0xFFFFFFFE, cout=0, ovf=0.
